// File: rtl/lane_fifo_pkg.sv
// Shared definitions for the multi-lane AXI-Stream FIFO: drain mode encodings,
// stall counter width and the per-lane level width helper.
package lane_fifo_pkg;

  typedef enum logic {
    SYNC_INDEP    = 1'b0,
    SYNC_LOCKSTEP = 1'b1
  } sync_mode_e;

  localparam int STALL_W = 16;

  // Level needs one more bit than the pointers so a full FIFO is representable.
  function automatic int lvl_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/lane_sync_fifo.sv
// Single-clock FIFO for one lane. Head word is read straight from memory at
// the read pointer; push is refused when full and pop is ignored when empty.
module lane_sync_fifo import lane_fifo_pkg::*; #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic [lvl_w(DEPTH)-1:0]  level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = lvl_w(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             do_push, do_pop;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    do_push  = push && (level_q != LVL_W'(DEPTH));
    do_pop   = pop && (level_q != '0);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_q] <= wr_data;
    end
  end

  assign rd_data = mem[rd_ptr_q];
  assign level   = level_q;

endmodule

// File: rtl/axis_lane_fifo.sv
// Splits one wide AXI-Stream word into NUM_LANES per-lane FIFOs, each drained
// independently or in lockstep, with a sticky error on a long input stall.
module axis_lane_fifo import lane_fifo_pkg::*; #(
  parameter int NUM_LANES   = 3,
  parameter int DATA_WIDTH  = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int AFULL_LEVEL = FIFO_DEPTH - 1,
  parameter int SYNC_OUT    = 0
) (
  input  logic                                    clk,
  input  logic                                    rstn,
  input  logic [NUM_LANES*DATA_WIDTH-1:0]         s_axis_tdata,
  input  logic                                    s_axis_tvalid,
  input  logic                                    s_axis_tlast,
  output logic                                    s_axis_tready,
  output logic [NUM_LANES*DATA_WIDTH-1:0]         m_axis_tdata,
  output logic [NUM_LANES-1:0]                    m_axis_tvalid,
  output logic [NUM_LANES-1:0]                    m_axis_tlast,
  input  logic [NUM_LANES-1:0]                    m_axis_tready,
  output logic [NUM_LANES*lvl_w(FIFO_DEPTH)-1:0]  lane_level,
  output logic [NUM_LANES-1:0]                    lane_afull,
  output logic                                    overflow_err
);

  localparam int LVL_W = lvl_w(FIFO_DEPTH);
  localparam bit LOCKSTEP = (SYNC_OUT == int'(SYNC_LOCKSTEP));
  localparam logic [STALL_W-1:0] STALL_MAX = '1;

  logic [DATA_WIDTH:0]  head  [NUM_LANES];
  logic [LVL_W-1:0]     level [NUM_LANES];
  logic [NUM_LANES-1:0] not_full, not_empty, m_valid, pop;
  logic                 in_ready, push, stall;
  logic                 ready_en_q, ready_en_d;
  logic [STALL_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic                 overflow_q, overflow_d;

  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
    lane_sync_fifo #(
      .WIDTH (DATA_WIDTH + 1),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk     (clk),
      .rstn    (rstn),
      .push    (push),
      .wr_data ({s_axis_tlast, s_axis_tdata[gi*DATA_WIDTH +: DATA_WIDTH]}),
      .pop     (pop[gi]),
      .rd_data (head[gi]),
      .level   (level[gi])
    );
  end

  // Input ready looks only at registered levels, so a full lane blocks input
  // even in the cycle it pops; ready_en_q holds ready low until after reset.
  always_comb begin
    not_full  = '0;
    not_empty = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      not_full[i]  = level[i] < LVL_W'(FIFO_DEPTH);
      not_empty[i] = level[i] != '0;
    end
    in_ready = ready_en_q && (&not_full);
    push     = s_axis_tvalid && in_ready;
    if (LOCKSTEP) begin
      m_valid = ((&not_empty) && (&m_axis_tready)) ? '1 : '0;
    end else begin
      m_valid = not_empty;
    end
    pop = m_valid & m_axis_tready;
  end

  always_comb begin
    m_axis_tdata = '0;
    m_axis_tlast = '0;
    lane_level   = '0;
    lane_afull   = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      m_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH] = m_valid[i] ? head[i][DATA_WIDTH-1:0] : '0;
      m_axis_tlast[i]                          = m_valid[i] && head[i][DATA_WIDTH];
      lane_level[i*LVL_W +: LVL_W]             = level[i];
      lane_afull[i]                            = level[i] >= LVL_W'(AFULL_LEVEL);
    end
  end

  // The error fires on the stall cycle that arrives with the counter saturated.
  always_comb begin
    stall       = s_axis_tvalid && !in_ready;
    ready_en_d  = 1'b1;
    stall_cnt_d = '0;
    if (stall) begin
      stall_cnt_d = (stall_cnt_q == STALL_MAX) ? stall_cnt_q : stall_cnt_q + STALL_W'(1);
    end
    overflow_d = overflow_q || (stall && (stall_cnt_q == STALL_MAX));
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ready_en_q  <= 1'b0;
      stall_cnt_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      ready_en_q  <= ready_en_d;
      stall_cnt_q <= stall_cnt_d;
      overflow_q  <= overflow_d;
    end
  end

  assign s_axis_tready = in_ready;
  assign m_axis_tvalid = m_valid;
  assign overflow_err  = overflow_q;

endmodule

// File: tb/tb_axis_lane_fifo.sv
// Bench for axis_lane_fifo: one independent-drain and one lockstep instance,
// table-driven fill/drain vectors plus per-lane scoreboards on every pop.
module tb_axis_lane_fifo;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic [23:0] a_tdata, a_mdata, b_tdata, b_mdata;
  logic        a_tvalid, a_tlast, a_tready, a_ovf;
  logic        b_tvalid, b_tlast, b_tready, b_ovf;
  logic [2:0]  a_mvalid, a_mlast, a_mready, a_afull;
  logic [2:0]  b_mvalid, b_mlast, b_mready, b_afull;
  logic [8:0]  a_level, b_level;

  axis_lane_fifo #(
    .NUM_LANES(3), .DATA_WIDTH(8), .FIFO_DEPTH(4), .AFULL_LEVEL(3), .SYNC_OUT(0)
  ) dut_a (
    .clk(clk), .rstn(rstn),
    .s_axis_tdata(a_tdata), .s_axis_tvalid(a_tvalid), .s_axis_tlast(a_tlast),
    .s_axis_tready(a_tready),
    .m_axis_tdata(a_mdata), .m_axis_tvalid(a_mvalid), .m_axis_tlast(a_mlast),
    .m_axis_tready(a_mready),
    .lane_level(a_level), .lane_afull(a_afull), .overflow_err(a_ovf)
  );

  axis_lane_fifo #(
    .NUM_LANES(3), .DATA_WIDTH(8), .FIFO_DEPTH(4), .AFULL_LEVEL(3), .SYNC_OUT(1)
  ) dut_b (
    .clk(clk), .rstn(rstn),
    .s_axis_tdata(b_tdata), .s_axis_tvalid(b_tvalid), .s_axis_tlast(b_tlast),
    .s_axis_tready(b_tready),
    .m_axis_tdata(b_mdata), .m_axis_tvalid(b_mvalid), .m_axis_tlast(b_mlast),
    .m_axis_tready(b_mready),
    .lane_level(b_level), .lane_afull(b_afull), .overflow_err(b_ovf)
  );

  int vec_cnt = 0;
  int miscmp_cnt = 0;

  logic [8:0]  sb_a [3][$];
  logic [24:0] sb_b [$];

  typedef struct {
    logic [23:0] tdata;
    logic        tvalid;
    logic        tlast;
    logic [2:0]  mready;
    logic        exp_tready;
    logic [2:0]  exp_mvalid;
    logic [23:0] exp_mdata;
    logic [2:0]  exp_mlast;
    logic [8:0]  exp_level;
    logic [2:0]  exp_afull;
  } vec_t;

  vec_t vecs[17];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vec_cnt++;
    if (actual !== expected) begin
      miscmp_cnt++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    a_tdata  = v.tdata;
    a_tvalid = v.tvalid;
    a_tlast  = v.tlast;
    a_mready = v.mready;
    @(negedge clk);
    checkOutput($sformatf("v%0d_tready", idx), 32'(a_tready), 32'(v.exp_tready));
    checkOutput($sformatf("v%0d_mvalid", idx), 32'(a_mvalid), 32'(v.exp_mvalid));
    checkOutput($sformatf("v%0d_mdata", idx),  32'(a_mdata),  32'(v.exp_mdata));
    checkOutput($sformatf("v%0d_mlast", idx),  32'(a_mlast),  32'(v.exp_mlast));
    checkOutput($sformatf("v%0d_level", idx),  32'(a_level),  32'(v.exp_level));
    checkOutput($sformatf("v%0d_afull", idx),  32'(a_afull),  32'(v.exp_afull));
    @(posedge clk);
    #1;
  endtask

  // Scoreboards: pops are compared against the words accepted earlier.
  always @(negedge clk) begin
    logic [8:0]  exp_a;
    logic [24:0] exp_b;
    if (!rstn) begin
      for (int i = 0; i < 3; i++) sb_a[i].delete();
      sb_b.delete();
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (a_mvalid[i] && a_mready[i]) begin
          if (sb_a[i].size() != 0) exp_a = sb_a[i].pop_front();
          else exp_a = 'x;
          checkOutput($sformatf("sbA_lane%0d", i), 32'({a_mlast[i], a_mdata[i*8 +: 8]}), 32'(exp_a));
        end
      end
      if (a_tvalid && a_tready) begin
        for (int i = 0; i < 3; i++) sb_a[i].push_back({a_tlast, a_tdata[i*8 +: 8]});
      end
      if (b_mvalid != 3'b000) begin
        checkOutput("sbB_allvalid", 32'({b_mvalid, b_mready}), 32'({3'b111, 3'b111}));
        if (sb_b.size() != 0) exp_b = sb_b.pop_front();
        else exp_b = 'x;
        checkOutput("sbB_word", 32'({b_mlast, b_mdata}), 32'({{3{exp_b[24]}}, exp_b[23:0]}));
      end
      if (b_tvalid && b_tready) sb_b.push_back({b_tlast, b_tdata});
    end
  end

  initial begin
    a_tdata = '0; a_tvalid = 1'b0; a_tlast = 1'b0; a_mready = '0;
    b_tdata = '0; b_tvalid = 1'b0; b_tlast = 1'b0; b_mready = '0;

    vecs[0]  = '{24'hAABBCC, 1'b1, 1'b0, 3'b000, 1'b1, 3'b000, 24'h000000, 3'b000, 9'o000, 3'b000};
    vecs[1]  = '{24'h112233, 1'b1, 1'b0, 3'b000, 1'b1, 3'b111, 24'hAABBCC, 3'b000, 9'o111, 3'b000};
    vecs[2]  = '{24'hDDEEFF, 1'b1, 1'b0, 3'b000, 1'b1, 3'b111, 24'hAABBCC, 3'b000, 9'o222, 3'b000};
    vecs[3]  = '{24'h445566, 1'b1, 1'b1, 3'b000, 1'b1, 3'b111, 24'hAABBCC, 3'b000, 9'o333, 3'b111};
    vecs[4]  = '{24'h778899, 1'b1, 1'b0, 3'b000, 1'b0, 3'b111, 24'hAABBCC, 3'b000, 9'o444, 3'b111};
    vecs[5]  = '{24'h778899, 1'b1, 1'b0, 3'b000, 1'b0, 3'b111, 24'hAABBCC, 3'b000, 9'o444, 3'b111};
    vecs[6]  = '{24'h778899, 1'b1, 1'b0, 3'b000, 1'b0, 3'b111, 24'hAABBCC, 3'b000, 9'o444, 3'b111};
    vecs[7]  = '{24'h778899, 1'b1, 1'b0, 3'b111, 1'b0, 3'b111, 24'hAABBCC, 3'b000, 9'o444, 3'b111};
    vecs[8]  = '{24'h778899, 1'b1, 1'b0, 3'b000, 1'b1, 3'b111, 24'h112233, 3'b000, 9'o333, 3'b111};
    vecs[9]  = '{24'h000000, 1'b0, 1'b0, 3'b000, 1'b0, 3'b111, 24'h112233, 3'b000, 9'o444, 3'b111};
    vecs[10] = '{24'h000000, 1'b0, 1'b0, 3'b001, 1'b0, 3'b111, 24'h112233, 3'b000, 9'o444, 3'b111};
    vecs[11] = '{24'h000000, 1'b0, 1'b0, 3'b001, 1'b0, 3'b111, 24'h1122FF, 3'b000, 9'o443, 3'b111};
    vecs[12] = '{24'h000000, 1'b0, 1'b0, 3'b001, 1'b0, 3'b111, 24'h112266, 3'b001, 9'o442, 3'b110};
    vecs[13] = '{24'h000000, 1'b0, 1'b0, 3'b001, 1'b0, 3'b111, 24'h112299, 3'b000, 9'o441, 3'b110};
    vecs[14] = '{24'h000000, 1'b0, 1'b0, 3'b000, 1'b0, 3'b110, 24'h112200, 3'b000, 9'o440, 3'b110};
    vecs[15] = '{24'h000000, 1'b0, 1'b0, 3'b001, 1'b0, 3'b110, 24'h112200, 3'b000, 9'o440, 3'b110};
    vecs[16] = '{24'h000000, 1'b0, 1'b0, 3'b000, 1'b0, 3'b110, 24'h112200, 3'b000, 9'o440, 3'b110};

    // Power-on reset, then release mid-cycle.
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_tready", 32'({a_tready, b_tready}), 32'(2'b00));
    checkOutput("rst_mvalid", 32'({a_mvalid, b_mvalid}), 32'(6'b0));
    checkOutput("rst_mlast",  32'({a_mlast, b_mlast}),   32'(6'b0));
    checkOutput("rst_level",  32'({a_level, b_level}),   32'(18'b0));
    checkOutput("rst_afull",  32'({a_afull, b_afull}),   32'(6'b0));
    checkOutput("rst_ovf",    32'({a_ovf, b_ovf}),       32'(2'b00));
    rstn = 1'b1;
    @(negedge clk);
    checkOutput("rel_tready_pre_edge", 32'(a_tready), 32'(1'b0));
    @(posedge clk);
    #1;
    checkOutput("rel_tready_post_edge", 32'({a_tready, b_tready}), 32'(2'b11));

    $display("[TB] fill / single read / independent drain");
    for (int i = 0; i < 17; i++) applyStimulus(vecs[i], i);

    // Drain the rest of lanes 1/2, then stream with push and pop together.
    a_tvalid = 1'b0;
    a_mready = 3'b111;
    repeat (5) @(posedge clk);
    #1;
    checkOutput("drain_level",  32'(a_level),  32'(9'o000));
    checkOutput("drain_mvalid", 32'(a_mvalid), 32'(3'b000));
    for (int k = 0; k < 6; k++) begin
      a_tdata  = 24'h0A0B0C + k * 24'h010101;
      a_tlast  = k[0];
      a_tvalid = 1'b1;
      if (k > 0) checkOutput($sformatf("stream%0d_level", k), 32'(a_level), 32'(9'o111));
      @(posedge clk);
      #1;
    end
    a_tvalid = 1'b0;
    checkOutput("stream_end_level", 32'(a_level), 32'(9'o111));
    @(posedge clk);
    #1;
    checkOutput("stream_empty_level", 32'(a_level), 32'(9'o000));
    a_mready = 3'b000;

    $display("[TB] lockstep drain");
    b_tvalid = 1'b1; b_tdata = 24'h102030; b_tlast = 1'b0;
    @(posedge clk);
    #1;
    b_tdata = 24'h405060; b_tlast = 1'b1;
    @(posedge clk);
    #1;
    b_tvalid = 1'b0;
    checkOutput("lock_level2", 32'(b_level), 32'(9'o222));
    b_mready = 3'b011;
    #1;
    checkOutput("lock_partial_mvalid", 32'(b_mvalid), 32'(3'b000));
    @(posedge clk);
    #1;
    checkOutput("lock_partial_level", 32'(b_level), 32'(9'o222));
    b_mready = 3'b111;
    #1;
    checkOutput("lock_w0_mvalid", 32'(b_mvalid), 32'(3'b111));
    checkOutput("lock_w0_data",   32'({b_mlast, b_mdata}), 32'({3'b000, 24'h102030}));
    @(posedge clk);
    #1;
    checkOutput("lock_w1_data",   32'({b_mlast, b_mdata}), 32'({3'b111, 24'h405060}));
    @(posedge clk);
    #1;
    checkOutput("lock_empty", 32'({b_mvalid, b_level}), 32'({3'b000, 9'o000}));
    b_mready = 3'b000;

    $display("[TB] reset mid-fill");
    a_tvalid = 1'b1; a_tdata = 24'h313233; a_tlast = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("mid_level2", 32'(a_level), 32'(9'o222));
    a_tdata = 24'h5A5A5A; a_tlast = 1'b1;
    rstn = 1'b0;
    #2;
    checkOutput("mid_rst_level",  32'(a_level),  32'(9'o000));
    checkOutput("mid_rst_mvalid", 32'(a_mvalid), 32'(3'b000));
    checkOutput("mid_rst_tready", 32'(a_tready), 32'(1'b0));
    @(posedge clk);
    #1;
    rstn = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("post_rst_state", 32'({a_tready, a_level, a_mvalid}), 32'({1'b1, 9'o000, 3'b000}));
    @(posedge clk);
    #1;
    a_tvalid = 1'b0;
    checkOutput("post_rst_latency", 32'({a_mvalid, a_mlast, a_mdata}), 32'({3'b111, 3'b111, 24'h5A5A5A}));
    a_mready = 3'b111;
    @(posedge clk);
    #1;
    a_mready = 3'b000;

    $display("[TB] stall error");
    a_tvalid = 1'b1; a_tdata = 24'h777777; a_tlast = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checkOutput("stall_full", 32'({a_tready, a_level}), 32'({1'b0, 9'o444}));
    repeat (65535) @(posedge clk);
    #1;
    checkOutput("stall_65535_ovf", 32'(a_ovf), 32'(1'b0));
    @(posedge clk);
    #1;
    checkOutput("stall_65536_ovf", 32'(a_ovf), 32'(1'b1));
    a_tvalid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("stall_sticky_ovf", 32'({a_ovf, b_ovf}), 32'(2'b10));
    rstn = 1'b0;
    #2;
    checkOutput("stall_rst_ovf", 32'(a_ovf), 32'(1'b0));
    rstn = 1'b1;
    repeat (2) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp_cnt);
    $finish;
  end

endmodule
